// File: rtl/vector_op_arbiter_pkg.sv
// vp_pkg: opcodes, FSM encoding and default widths shared by the vector processor slice
package vp_pkg;
    localparam int VP_LANES  = 4;
    localparam int VP_DATA_W = 16;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_SCALE = 4'h3;
    localparam logic [3:0] OP_DOT   = 4'h4;
    localparam logic [3:0] OP_MIN   = 4'h5;
    localparam logic [3:0] OP_CLAMP = 4'h6;
    localparam logic [3:0] OP_LERP  = 4'h7;
    localparam logic [3:0] OP_MAX   = 4'h7;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/vector_op_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        // walk offsets from farthest to nearest so the nearest set request overwrites last
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= N ? j - N : j;
            if (req[j]) begin
                grant = N'(1) << j;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/vector_op_arbiter.sv
// vector_op_arbiter: shares one vector_processor among NUM_REQ requesters, one op in flight,
// round-robin grant, operands held for the whole op, result routed back, timeout on a hung datapath
module vector_op_arbiter
    import vp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int VECTOR_WIDTH   = VP_LANES,
    parameter int DATA_WIDTH     = VP_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*4-1:0]                      req_op,
    input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_a,
    input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]             req_scalar,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    input  logic [NUM_REQ-1:0]                        rsp_ready,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        rsp_data,
    output logic                                      rsp_error,
    output logic                                      vp_start,
    output logic [3:0]                                vp_operation,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_a,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_b,
    output logic [DATA_WIDTH-1:0]                     vp_scalar,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_result,
    input  logic                                      vp_result_valid,
    output logic                                      busy,
    output logic [15:0]                               op_count
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int VW    = VECTOR_WIDTH * DATA_WIDTH;
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] win_idx;
    logic [NUM_REQ-1:0] win;
    logic [CW-1:0]    tmo;
    logic [3:0]       sel_op;
    logic             xfer;

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win),
        .idx   (win_idx)
    );

    assign req_ready = state == ST_IDLE ? win : '0;
    assign xfer      = |(req_valid & req_ready);
    assign sel_op    = req_op[win_idx*4 +: 4];
    assign rsp_valid = state == ST_RESP ? NUM_REQ'(1) << g_idx : '0;
    assign vp_start  = state == ST_ISSUE;
    assign busy      = state != ST_IDLE;

    // the vp_* operand outputs are the capture registers themselves, so they hold until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            g_idx        <= '0;
            tmo          <= '0;
            op_count     <= '0;
            vp_operation <= '0;
            vp_vec_a     <= '0;
            vp_vec_b     <= '0;
            vp_scalar    <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (xfer) begin
                    g_idx        <= win_idx;
                    vp_operation <= sel_op;
                    vp_vec_a     <= req_vec_a[win_idx*VW +: VW];
                    vp_vec_b     <= req_vec_b[win_idx*VW +: VW];
                    vp_scalar    <= req_scalar[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    rsp_data     <= '0;
                    rsp_error    <= sel_op > OP_MAX;
                    state        <= sel_op > OP_MAX ? ST_RESP : ST_ISSUE;
                end
                ST_ISSUE: begin
                    tmo   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: if (vp_result_valid) begin
                    rsp_data  <= vp_result;
                    rsp_error <= 1'b0;
                    state     <= ST_RESP;
                end else begin
                    tmo <= tmo + 1'b1;
                    if (tmo == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: if (rsp_ready[g_idx]) begin
                    op_count <= op_count + 1'b1;
                    rr_ptr   <= g_idx == IDX_W'(NUM_REQ - 1) ? '0 : g_idx + 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_op_arbiter.sv
// tb_vector_op_arbiter: directed tests with a per-cycle transaction-level model of the arbiter
module tb_vector_op_arbiter;
    localparam int N  = 4;
    localparam int VW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] rsp_valid;
    logic [N-1:0] rsp_ready = '0;
    logic [N*4-1:0] req_op = '0;
    logic [N*VW-1:0] req_vec_a = '0;
    logic [N*VW-1:0] req_vec_b = '0;
    logic [N*16-1:0] req_scalar = '0;
    logic [VW-1:0] rsp_data, vp_vec_a, vp_vec_b;
    logic [VW-1:0] vp_result = '0;
    logic rsp_error, vp_start, busy;
    logic vp_result_valid = 1'b0;
    logic [3:0] vp_operation;
    logic [15:0] vp_scalar, op_count;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic dp_en = 1'b1;
    logic inject = 1'b0;

    vector_op_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_vec_a(req_vec_a), .req_vec_b(req_vec_b), .req_scalar(req_scalar),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .vp_start(vp_start), .vp_operation(vp_operation), .vp_vec_a(vp_vec_a), .vp_vec_b(vp_vec_b),
        .vp_scalar(vp_scalar), .vp_result(vp_result), .vp_result_valid(vp_result_valid),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] dp_fn(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [15:0] s);
        logic [63:0] r;
        for (int l = 0; l < 4; l++)
            r[l*16 +: 16] = op == 4'h0 ? a[l*16 +: 16] + b[l*16 +: 16] : a[l*16 +: 16] ^ b[l*16 +: 16] ^ s;
        return r;
    endfunction

    function automatic int arb(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // datapath stand-in: reads operands in stage 2, answers two cycles after vp_start
    initial begin
        logic p1 = 1'b0;
        logic p2 = 1'b0;
        logic [63:0] r2 = '0;
        forever begin
            @(posedge clk);
            #1;
            vp_result_valid = p2 | inject;
            vp_result = p2 ? r2 : 64'hDEAD_BEEF_0BAD_F00D;
            p2 = p1;
            r2 = dp_fn(vp_operation, vp_vec_a, vp_vec_b, vp_scalar);
            p1 = vp_start & dp_en;
        end
    end

    // model: one outstanding op described by acceptance cycle, response cycle and expected payload
    initial begin
        int m_ptr = 0;
        int m_g = 0;
        int t_acc = 0;
        int t_rsp = 0;
        int w;
        logic m_idle = 1'b1;
        logic m_legal = 1'b0;
        logic m_err = 1'b0;
        logic [15:0] m_cnt = '0;
        logic [3:0] m_op = '0;
        logic [63:0] m_a = '0;
        logic [63:0] m_b = '0;
        logic [63:0] m_d = '0;
        logic [15:0] m_s = '0;
        logic [N-1:0] e_ready, e_rv;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_idle = 1'b1;
                m_ptr = 0;
                m_cnt = '0;
                e_ready = '0;
                w = arb(req_valid, 0);
                if (w >= 0) e_ready[w] = 1'b1;
                chk("rst_req_ready", req_ready, e_ready);
                chk("rst_ctrl", {rsp_valid, rsp_error, vp_start, busy, vp_operation, op_count}, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_vp_vec_a", vp_vec_a, 0);
                chk("rst_vp_vec_b", vp_vec_b, 0);
                chk("rst_vp_scalar", vp_scalar, 0);
            end else begin
                w = m_idle ? arb(req_valid, m_ptr) : -1;
                e_ready = '0;
                e_rv = '0;
                if (w >= 0) e_ready[w] = 1'b1;
                if (!m_idle && cyc >= t_rsp) e_rv[m_g] = 1'b1;
                chk("req_ready", req_ready, e_ready);
                chk("busy", busy, !m_idle);
                chk("vp_start", vp_start, !m_idle && m_legal && cyc == t_acc + 1);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("op_count", op_count, m_cnt);
                if (e_rv != 0) begin
                    chk("rsp_data", rsp_data, m_d);
                    chk("rsp_error", rsp_error, m_err);
                end
                if (!m_idle && m_legal) begin
                    chk("vp_operation", vp_operation, m_op);
                    chk("vp_vec_a", vp_vec_a, m_a);
                    chk("vp_vec_b", vp_vec_b, m_b);
                    chk("vp_scalar", vp_scalar, m_s);
                end
                if (w >= 0) begin
                    m_g = w;
                    m_op = req_op[w*4 +: 4];
                    m_a = req_vec_a[w*VW +: VW];
                    m_b = req_vec_b[w*VW +: VW];
                    m_s = req_scalar[w*16 +: 16];
                    m_legal = m_op <= 4'h7;
                    t_acc = cyc;
                    m_idle = 1'b0;
                    if (!m_legal) begin
                        t_rsp = cyc + 1; m_err = 1'b1; m_d = '0;
                    end else if (dp_en) begin
                        t_rsp = cyc + 4; m_err = 1'b0; m_d = dp_fn(m_op, m_a, m_b, m_s);
                    end else begin
                        t_rsp = cyc + 2 + 16; m_err = 1'b1; m_d = '0;
                    end
                end else if (e_rv != 0 && rsp_ready[m_g]) begin
                    m_cnt++;
                    m_ptr = (m_g + 1) % N;
                    m_idle = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [15:0] s);
        req_op[r*4 +: 4] = op;
        req_vec_a[r*VW +: VW] = a;
        req_vec_b[r*VW +: VW] = b;
        req_scalar[r*16 +: 16] = s;
    endtask

    task automatic wait_xfer(output int idx, output int t);
        idx = -1;
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++) begin
            sample();
            if (|(req_valid & req_ready)) begin
                t = cyc;
                idx = arb(req_valid & req_ready, 0);
            end
        end
        if (t < 0) chk("xfer_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++) begin
            sample();
            if (rsp_valid != 0) t = cyc;
        end
        if (t < 0) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        int idx, t, tp, tr;
        logic [63:0] d0;
        #1 rst_n = 1'b0;
        repeat (3) sample();
        chk("reset_busy", busy, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_rsp_valid", rsp_valid, 0);

        // contention from reset: grants 0,1,2,3,0 five cycles apart
        step();
        rst_n = 1'b1;
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        tp = 0;
        for (int g = 0; g < 5; g++) begin
            wait_xfer(idx, t);
            chk("cont_order", idx, g % 4);
            if (g > 0) chk("cont_gap", t - tp, 5);
            tp = t;
        end
        step();
        req_valid = '0;
        wait_rsp(tr);
        sample();
        chk("cont_op_count", op_count, 5);

        // single ADD from requester 1
        set_req(1, 4'h0, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100, 16'h0);
        step();
        req_valid = 4'b0010;
        wait_xfer(idx, t);
        chk("add_idx", idx, 1);
        step();
        req_valid = '0;
        sample();
        chk("add_vp_start_t1", vp_start, 1);
        sample();
        sample();
        chk("add_no_rsp_t3", rsp_valid, 0);
        sample();
        chk("add_rsp_valid_t4", rsp_valid, 4'b0010);
        chk("add_rsp_data", rsp_data, 64'h0500_0400_0300_0200);
        chk("add_rsp_error", rsp_error, 0);

        // illegal opcode from requester 2
        set_req(2, 4'hA, 64'h1234_5678_9ABC_DEF0, 64'h1, 16'h7);
        step();
        req_valid = 4'b0100;
        wait_xfer(idx, t);
        chk("ill_idx", idx, 2);
        step();
        req_valid = '0;
        sample();
        chk("ill_no_start", vp_start, 0);
        chk("ill_rsp_valid_t1", rsp_valid, 4'b0100);
        chk("ill_rsp_error", rsp_error, 1);
        chk("ill_rsp_data", rsp_data, 0);

        // hung datapath, then a normal op
        step();
        dp_en = 1'b0;
        set_req(0, 4'h1, 64'h5555_5555_5555_5555, 64'h1, 16'h2);
        req_valid = 4'b0001;
        wait_xfer(idx, t);
        step();
        req_valid = '0;
        wait_rsp(tr);
        chk("tmo_latency", tr - t, 18);
        chk("tmo_rsp_error", rsp_error, 1);
        chk("tmo_rsp_data", rsp_data, 0);
        step();
        dp_en = 1'b1;
        set_req(1, 4'h0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 16'h0);
        req_valid = 4'b0010;
        wait_xfer(idx, t);
        step();
        req_valid = '0;
        wait_rsp(tr);
        chk("post_tmo_latency", tr - t, 4);
        chk("post_tmo_error", rsp_error, 0);
        chk("post_tmo_data", rsp_data, 64'h0011_0022_0033_0044);

        // backpressure on requester 0 while requester 3 waits
        step();
        rsp_ready = 4'b1110;
        set_req(0, 4'h2, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 16'h00FF);
        set_req(3, 4'h0, 64'h0, 64'h0, 16'h0);
        req_valid = 4'b0001;
        wait_xfer(idx, t);
        chk("bp_idx", idx, 0);
        step();
        req_valid = 4'b1000;
        wait_rsp(tr);
        d0 = rsp_data;
        chk("bp_data_literal", d0, 64'h1EE1_2DD2_3CC3_4BB4);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) sample();
            chk("bp_rsp_valid", rsp_valid, 4'b0001);
            chk("bp_data_stable", rsp_data, d0);
            chk("bp_req_ready", req_ready, 0);
        end
        step();
        rsp_ready = 4'hF;
        sample();
        chk("bp_accept_cycle", rsp_valid, 4'b0001);
        sample();
        chk("bp_req3_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_rsp(tr);

        // reset while waiting on the datapath
        set_req(2, 4'h0, 64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 16'h0);
        step();
        req_valid = 4'b0100;
        wait_xfer(idx, t);
        step();
        req_valid = '0;
        wait_rsp(tr);
        step();
        req_valid = 4'b0100;
        wait_xfer(idx, t);
        step();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b0;
        sample();
        chk("wrst_busy", busy, 0);
        chk("wrst_op_count", op_count, 0);
        chk("wrst_vp_vec_a", vp_vec_a, 0);
        step();
        rst_n = 1'b1;
        step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        sample();
        chk("wrst_late_result", rsp_valid, 0);
        chk("wrst_late_busy", busy, 0);
        step();
        req_valid = 4'b1001;
        sample();
        chk("wrst_ptr_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_rsp(tr);
        repeat (3) sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, want finish earlier");
        $fatal(1);
    end
endmodule

// File: doc/vector_op_arbiter.md
Name: vector_op_arbiter

Overview:
- Shares one vector_processor instance (4-lane, 16-bit 8.8 fixed point, 2-cycle result latency) among NUM_REQ shader requesters.
- Round-robin arbitration, valid/ready request handshake and one operation in flight at a time.
- Holds operands stable for the whole operation, routes the result back to the granting requester, and guards against a hung datapath with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VECTOR_WIDTH, 4, lanes per vector.
- DATA_WIDTH, 16, bits per lane.
- TIMEOUT_CYCLES, 16, WAIT cycles before the op is aborted with an error.
- IDX_W, $clog2(NUM_REQ), localparam, requester index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_op  in  NUM_REQ*4  operation codes, requester i at [i*4+:4]
- req_vec_a  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand A, per requester
- req_vec_b  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand B, per requester
- req_scalar  in  NUM_REQ*DATA_WIDTH  scalar, per requester
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  VECTOR_WIDTH*DATA_WIDTH  result, shared by all requesters
- rsp_error  out  1  1 = illegal op or timeout
- vp_start  out  1  single-cycle start to the vector processor
- vp_operation  out  4  operation code to the datapath
- vp_vec_a  out  VECTOR_WIDTH*DATA_WIDTH  operand A to the datapath
- vp_vec_b  out  VECTOR_WIDTH*DATA_WIDTH  operand B to the datapath
- vp_scalar  out  DATA_WIDTH  scalar to the datapath
- vp_result  in  VECTOR_WIDTH*DATA_WIDTH  datapath result
- vp_result_valid  in  1  datapath result strobe
- busy  out  1  state != IDLE
- op_count  out  16  operations completed; wraps; includes errored ops

Behaviour:
- Reset: every output 0. State IDLE, rr_ptr 0, grant index 0, timeout counter 0, op_count 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit g wins.
  - req_ready[g] is combinational: high only in IDLE and only for the winner.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - On transfer, capture op, vec_a, vec_b and scalar into registers and store g.
  - Next state is ISSUE if op <= 4'h7; otherwise RESP with rsp_error=1 and rsp_data=0, and no vp_start is issued.
- ISSUE: vp_start=1 for exactly one cycle; clear the timeout counter; next state WAIT.
- Operand hold: vp_operation, vp_vec_a, vp_vec_b and vp_scalar are driven from the capture registers and stay constant from ISSUE until RESP is left. The datapath reads operands combinationally in its stage 2.
- WAIT:
  - On vp_result_valid: rsp_data <= vp_result, rsp_error <= 0, next state RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: rsp_error <= 1, rsp_data <= 0, next state RESP.
  - vp_result_valid sampled outside WAIT is ignored.
- RESP:
  - rsp_valid[g]=1. rsp_data and rsp_error are held stable until rsp_ready[g].
  - On acceptance: op_count++, rr_ptr <= (g+1) mod NUM_REQ, next state IDLE.
  - rsp_ready on any other requester is ignored.
- Latency: request accepted in cycle T → vp_start in T+1 → vp_result_valid in T+3 → rsp_valid in T+4. Minimum 5 cycles per op with an immediately ready requester.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ operations.
- Reset mid-operation returns everything to reset values. A late vp_result_valid after reset is ignored (state is IDLE).
- Simultaneous rsp acceptance and new req_valid: the new grant happens only in the following IDLE cycle; no same-cycle bypass.

Decomposition:
- Package vp_pkg holds:
  - Operation codes OP_ADD..OP_LERP (0..7) and OP_MAX=4'h7.
  - FSM state encoding.
  - Default lane and data widths.
- Sub-module rr_arbiter:
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; reused by future texture/memory arbiters.

Test Plan:
- Single ADD: req1 sends a={0x0400,0x0300,0x0200,0x0100} (lane3..0), b=0x0100 per lane. Expect vp_start at T+1, rsp_valid=4'b0010 at T+4, rsp_data=0x0500_0400_0300_0200, rsp_error=0.
- Contention: all four req_valid high from reset, rsp_ready tied 1. Expect grant order 0,1,2,3, then 0 again, one grant every 5 cycles, op_count=5 after the fifth acceptance.
- Illegal op: req2 sends op=4'hA. Expect no vp_start, rsp_valid[2] at T+1 with rsp_error=1 and rsp_data=0.
- Timeout: datapath model never asserts result_valid. Expect rsp_error=1 and rsp_data=0 after 16 WAIT cycles; the next request is serviced normally.
- Backpressure: rsp_ready[0] held low 10 cycles while req3 is valid. Expect rsp_valid[0] and rsp_data stable, req_ready=0 throughout, and req3 granted 1 cycle after acceptance.
- Reset in WAIT: assert rst_n low during WAIT. Expect all outputs 0, rr_ptr=0; a following vp_result_valid pulse produces no rsp_valid.
